sync_fifo_param: RTL



---
 rtl/sync_fifo_param.sv | 87 ++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with threshold flags, sticky errors and optional FWFT output (FIFO_FWFT_EN)
module sync_fifo_param #(
  parameter int DBITS     = 8,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DBITS-1:0]  din,
  input  logic              rd_en,
  output logic [DBITS-1:0]  dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DBITS-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              rd_acc, wr_acc;
`ifndef FIFO_FWFT_EN
  logic [DBITS-1:0]  dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
`endif
  // accept decisions and next-state from pre-edge state; a read frees the slot a full write reuses
  always_comb begin
    rd_acc      = rd_en & ~empty;
    wr_acc      = wr_en & (~full | rd_en);
    wr_ptr_d    = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(rd_acc);
    count_d     = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    overflow_d  = overflow_q | (wr_en & ~wr_acc);
    underflow_d = underflow_q | (rd_en & ~rd_acc);
`ifndef FIFO_FWFT_EN
    dout_d       = rd_acc ? mem_q[rd_ptr_q] : dout_q;
    dout_valid_d = rd_acc;
`endif
  end
  // storage is not reset; only accepted writes touch it
  always_ff @(posedge clk) if (wr_acc && !reset) mem_q[wr_ptr_q] <= din;
  // control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
`ifndef FIFO_FWFT_EN
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
`ifndef FIFO_FWFT_EN
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`endif
    end
  end
  assign count        = count_q;
  assign empty        = count_q == '0;
  assign full         = count_q == (ADDR_W+1)'(DEPTH);
  assign almost_full  = count_q >= (ADDR_W+1)'(AFULL_TH);
  assign almost_empty = count_q <= (ADDR_W+1)'(AEMPTY_TH);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
`ifdef FIFO_FWFT_EN
  assign dout_valid   = ~empty;
  assign dout         = dout_valid ? mem_q[rd_ptr_q] : '0;
`else
  assign dout_valid   = dout_valid_q;
  assign dout         = dout_q;
`endif
endmodule
